// File: rtl/pn_seq_monitor.sv
// Receive-side checker for the 2-bit PN flip-flop counter (00->11->01->10->00).
// Tracks lock, flags illegal transitions and rebuilds the per-bit P/N excitation.
module pn_seq_monitor #(
    parameter int LOCK_N = 3,
    parameter int CW     = 8
) (
    input  logic          Clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [1:0]    state_in,
    output logic [1:0]    expected,
    output logic [1:0]    exc_p,
    output logic [1:0]    exc_n,
    output logic [1:0]    p_care,
    output logic [1:0]    n_care,
    output logic          locked,
    output logic          err,
    output logic [CW-1:0] err_count,
    output logic [CW-1:0] wrap_count
);

    // One spare bit so consec+1 never overflows when LOCK_N is 15.
    localparam int                CNT_W    = 5;
    localparam logic [CNT_W-1:0]  LOCK_LIM = CNT_W'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        LOCKED = 2'd2
    } fsm_t;

    function automatic logic [1:0] pn_next(input logic [1:0] s);
        logic [1:0] n;
        unique case (s)
            2'b00:   n = 2'b11;
            2'b11:   n = 2'b01;
            2'b01:   n = 2'b10;
            default: n = 2'b00;
        endcase
        return n;
    endfunction

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (&v) ? v : v + CW'(1);
    endfunction

    function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] v);
        return v + CW'(1);
    endfunction

    fsm_t             state_q, state_d;
    logic [1:0]       prev_q, prev_d;
    logic [CNT_W-1:0] consec_q, consec_d;
    logic [1:0]       expected_q, expected_d;
    logic [1:0]       exc_p_q, exc_p_d;
    logic [1:0]       exc_n_q, exc_n_d;
    logic [1:0]       p_care_q, p_care_d;
    logic [1:0]       n_care_q, n_care_d;
    logic             locked_q, locked_d;
    logic             err_q, err_d;
    logic [CW-1:0]    err_count_q, err_count_d;
    logic [CW-1:0]    wrap_count_q, wrap_count_d;

    logic [CNT_W-1:0] consec_inc;
    logic             seq_match;
    logic             is_wrap;

    assign consec_inc = consec_q + CNT_W'(1);
    assign seq_match  = (state_in == pn_next(prev_q));
    assign is_wrap    = (prev_q == 2'b10) && (state_in == 2'b00);

    always_ff @(posedge Clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            prev_q       <= '0;
            consec_q     <= '0;
            expected_q   <= '0;
            exc_p_q      <= '0;
            exc_n_q      <= '0;
            p_care_q     <= '0;
            n_care_q     <= '0;
            locked_q     <= 1'b0;
            err_q        <= 1'b0;
            err_count_q  <= '0;
            wrap_count_q <= '0;
        end else begin
            state_q      <= state_d;
            prev_q       <= prev_d;
            consec_q     <= consec_d;
            expected_q   <= expected_d;
            exc_p_q      <= exc_p_d;
            exc_n_q      <= exc_n_d;
            p_care_q     <= p_care_d;
            n_care_q     <= n_care_d;
            locked_q     <= locked_d;
            err_q        <= err_d;
            err_count_q  <= err_count_d;
            wrap_count_q <= wrap_count_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        prev_d       = prev_q;
        consec_d     = consec_q;
        expected_d   = expected_q;
        exc_p_d      = exc_p_q;
        exc_n_d      = exc_n_q;
        p_care_d     = p_care_q;
        n_care_d     = n_care_q;
        locked_d     = locked_q;
        err_d        = 1'b0;
        err_count_d  = err_count_q;
        wrap_count_d = wrap_count_q;

        if (in_valid) begin
            prev_d     = state_in;
            expected_d = pn_next(state_in);
            unique case (state_q)
                IDLE: begin
                    consec_d = '0;
                    state_d  = TRACK;
                end
                default: begin
                    // A flop at 0 only reveals its P input, a flop at 1 only its N input.
                    for (int i = 0; i < 2; i++) begin
                        if (prev_q[i]) begin
                            exc_n_d[i]  = state_in[i];
                            n_care_d[i] = 1'b1;
                            exc_p_d[i]  = 1'b0;
                            p_care_d[i] = 1'b0;
                        end else begin
                            exc_p_d[i]  = state_in[i];
                            p_care_d[i] = 1'b1;
                            exc_n_d[i]  = 1'b0;
                            n_care_d[i] = 1'b0;
                        end
                    end

                    if (seq_match) begin
                        consec_d = (consec_inc >= LOCK_LIM) ? LOCK_LIM : consec_inc;
                        if (consec_inc >= LOCK_LIM) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end else begin
                            state_d  = TRACK;
                            locked_d = 1'b0;
                        end
                        if (is_wrap) begin
                            wrap_count_d = wrap_inc(wrap_count_q);
                        end
                    end else begin
                        // The offending sample becomes the new reference, so
                        // tracking resumes from it on the very next sample.
                        err_d       = 1'b1;
                        err_count_d = sat_inc(err_count_q);
                        consec_d    = '0;
                        state_d     = TRACK;
                        locked_d    = 1'b0;
                    end
                end
            endcase
        end
    end

    assign expected   = expected_q;
    assign exc_p      = exc_p_q;
    assign exc_n      = exc_n_q;
    assign p_care     = p_care_q;
    assign n_care     = n_care_q;
    assign locked     = locked_q;
    assign err        = err_q;
    assign err_count  = err_count_q;
    assign wrap_count = wrap_count_q;

endmodule

// File: doc/pn_seq_monitor.md
Name: pn_seq_monitor

Overview:
- Receive-side companion to the 2-bit PN-flip-flop sequence counter (outputs FA, FB).
- Samples the counter's {FA,FB} state stream and checks it against the counter's legal sequence.
- Reconstructs the per-bit P/N excitation that must have produced each observed transition.
- Reports lock status, error pulses, an error count and a completed-period count for test and diagnostic logic.

Parameters:
LOCK_N, 3, consecutive legal transitions required to assert locked (1..15)
CW, 8, width of err_count and wrap_count

Ports:
Clk  input  1  clock, rising-edge active
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  state_in is sampled on this Clk edge
state_in  input  2  observed counter state {FA,FB}; bit1=FA, bit0=FB
expected  output  2  predicted next state after the last accepted sample
exc_p  output  2  reconstructed P input per bit for the last transition
exc_n  output  2  reconstructed N input per bit for the last transition
p_care  output  2  per bit, 1 = exc_p bit is meaningful (previous Q was 0)
n_care  output  2  per bit, 1 = exc_n bit is meaningful (previous Q was 1)
locked  output  1  LOCK_N consecutive legal transitions seen
err  output  1  one-cycle pulse on an illegal transition
err_count  output  CW  saturating count of illegal transitions
wrap_count  output  CW  count of legal 10->00 transitions, wraps modulo 2^CW

Behaviour:
- Reset (async, rst=1): all outputs 0, FSM=IDLE, prev=00, consec=0. rst dominates every other input.
- Legal sequence, next(s): 00->11, 11->01, 01->10, 10->00.
- Timing: all outputs are registered. Each update is visible after the Clk edge at which in_valid=1.
- in_valid=0: all state and outputs hold, except err, which is 0.
- FSM states: IDLE (no previous sample), TRACK (previous held, unlocked), LOCKED.
- IDLE with in_valid:
  - prev<=state_in; expected<=next(state_in); go to TRACK.
  - No err; excitation outputs unchanged; consec=0.
- TRACK/LOCKED with in_valid, for each bit i:
  - If prev[i]=0: exc_p[i]=state_in[i], p_care[i]=1, exc_n[i]=0, n_care[i]=0.
  - If prev[i]=1: exc_n[i]=state_in[i], n_care[i]=1, exc_p[i]=0, p_care[i]=0.
  - Then prev<=state_in and expected<=next(state_in).
- Match (state_in==next(prev)):
  - consec<=min(consec+1, LOCK_N).
  - If consec+1>=LOCK_N: go to LOCKED, locked=1.
  - If prev=10 and state_in=00: wrap_count<=wrap_count+1 (wraps to 0).
- Mismatch:
  - err=1 for one cycle; err_count+1, saturating at all-ones.
  - consec=0; go to TRACK, locked=0.
  - Excitation outputs still update from the observed transition.
  - The new sample becomes the reference, so resynchronisation is immediate.
- A repeated state (e.g. 11->11) is a mismatch. The sequence has no hold state.
- Reset mid-operation: counters, lock and excitation outputs clear immediately; the next sample re-enters via IDLE.
- State tracking, excitation decode and the saturating/wrapping counters must be implemented in RTL.

Test Plan:
- Reset: rst=1 pulse with no clock -> all outputs 0, err_count=0, locked=0; release -> still 0 until first in_valid.
- Lock acquisition (LOCK_N=3): feed 00,11,01,10,00 with in_valid=1 each cycle:
  - locked=1 after the 4th sample edge;
  - wrap_count=1 after the 5th sample;
  - expected=11 after the 5th sample;
  - err never set.
- Excitation decode on transition 01->10 -> exc_p=10, p_care=10, exc_n=00, n_care=01. On 11->01 -> exc_n=01, n_care=11, p_care=00.
- Error injection while locked: ...01,10,11 -> err=1 for exactly one cycle, err_count=1, locked=0. Then 01,10,00 -> locked=1 again, wrap_count increments.
- Saturation and wrap (CW=3): inject 9 illegal transitions -> err_count stays at 7. Run 9 legal periods -> wrap_count=1 (9 mod 8).
- in_valid gaps and mid-run reset:
  - Legal sequence with in_valid low for 3 cycles between samples -> identical results to the gap-free run, err=0 during the gaps.
  - Assert rst while locked=1 between clock edges -> outputs clear asynchronously; first post-reset sample produces no err.
